// File: rtl/ins_mem_loadable.sv
// Loadable instruction memory: streaming valid/ready load port, registered
// one-cycle fetch with a valid strobe. Fetches are refused while loading.
module ins_mem_loadable #(
  parameter int INS_W = 9,
  parameter int ADDR_W = 4,
  parameter logic [INS_W-1:0] RESET_INS = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch,
  output logic [INS_W-1:0]  ins,
  output logic              ins_valid,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [INS_W-1:0]  load_data,
  output logic              load_ready,
  output logic              load_done,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, LOAD} state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   wr_ptr_reg;
  logic [INS_W-1:0]    mem [DEPTH];
  logic                wr_en;

  // A restart pulse wins over any beat presented in the same cycle.
  assign wr_en = (state_reg == LOAD) && load_valid && !load_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RESET_INS;
      end
    end else if (wr_en) begin
      mem[wr_ptr_reg] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      wr_ptr_reg <= '0;
      ins        <= RESET_INS;
      ins_valid  <= 1'b0;
      load_ready <= 1'b0;
      load_done  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      ins_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          // The fetch reads the old contents even if a load starts now.
          if (fetch) begin
            ins       <= mem[pc];
            ins_valid <= 1'b1;
          end
          if (load_start) begin
            state_reg  <= LOAD;
            wr_ptr_reg <= '0;
            load_done  <= 1'b0;
            load_ready <= 1'b1;
            busy       <= 1'b1;
          end
        end
        LOAD: begin
          if (load_start) begin
            wr_ptr_reg <= '0;
          end else if (load_valid) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (&wr_ptr_reg) begin
              state_reg  <= IDLE;
              load_done  <= 1'b1;
              load_ready <= 1'b0;
              busy       <= 1'b0;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ins_mem_loadable.md
Name: ins_mem_loadable

Overview:
Parametrised instruction memory for the CPU fetch path, generalised to INS_W-bit instructions and 2^ADDR_W entries. Contents are written at run time through a streaming load port with a valid/ready handshake. Fetches are registered, with one-cycle latency and a valid strobe. The block sits between the program counter and the decoder; a boot/debug loader drives the load port.

Parameters:
INS_W, 9, instruction word width in bits
ADDR_W, 4, address width; DEPTH = 2^ADDR_W entries
RESET_INS, 0, value loaded into every memory entry and into ins on reset (INS_W bits)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
pc  input  ADDR_W  fetch address
fetch  input  1  fetch request, sampled each cycle
ins  output  INS_W  fetched instruction, registered
ins_valid  output  1  one-cycle pulse: ins updated this cycle
load_start  input  1  begin, or restart, a full-memory load from address 0
load_valid  input  1  load_data is valid
load_data  input  INS_W  instruction word to write
load_ready  output  1  block accepts load beats (state LOAD)
load_done  output  1  sticky flag: last load completed all DEPTH words
busy  output  1  high while in LOAD; fetches are refused

Behaviour:
Storage and reset
- DEPTH x INS_W storage built from flops.
- rst (sync, active-high) has priority over every other input:
  - every entry = RESET_INS; ins = RESET_INS
  - ins_valid = 0, load_ready = 0, load_done = 0, busy = 0
  - state = IDLE, wr_ptr = 0
- Reset asserted mid-load aborts the load. Partially written contents are overwritten with RESET_INS.

FSM, two states: IDLE and LOAD
- IDLE, load_start = 1: next state LOAD; wr_ptr = 0; load_done cleared to 0.
- LOAD, load_valid = 1 (load_ready is 1 in LOAD): mem[wr_ptr] = load_data; wr_ptr increments.
- LOAD, beat accepted with wr_ptr = DEPTH-1: mem[DEPTH-1] written; next state IDLE; load_done = 1 next cycle; wr_ptr wraps to 0.
- LOAD, load_start = 1: wr_ptr = 0; stay in LOAD. Any load_valid beat in the same cycle is discarded; load_start has priority.
- LOAD, load_valid = 0: hold; no timeout.
- load_ready and busy are registered, and equal (state == LOAD). Both fall the cycle after the final beat.
- load_done stays at 1 until the next load_start or rst.

Fetch
- IDLE, fetch = 1: the next cycle has ins = mem[pc] (contents at the sampling edge) and ins_valid = 1. Latency is exactly 1 cycle; back-to-back fetches give one result per cycle.
- fetch = 0, or state is LOAD: ins holds its previous value; ins_valid = 0 next cycle. Refused fetches are dropped, not queued.
- IDLE with fetch and load_start in the same cycle: the fetch is served from the old contents, then the FSM enters LOAD.
- Read-during-write cannot occur, because fetches are refused in LOAD.
- pc covers every address; no out-of-range case exists.

Widths
- wr_ptr is ADDR_W bits and wraps naturally.
- load_data is stored unmodified, with no sign or zero extension.

Test Plan:
1. Reset state (defaults): assert rst 2 cycles; fetch pc = 0..15 -> ins = 0x000 each cycle, ins_valid high the cycle after each fetch; load_done = 0.
2. Full load then fetch: load_start, then 16 beats of data = 0x100 + i (i = 0..15) -> load_ready high for the load, low the cycle after beat 15, load_done = 1. Fetch pc = 5 -> ins = 0x105 one cycle later; back-to-back pc = 15 then 0 -> 0x10F, 0x100.
3. Gapped handshake and blocked fetch: load_valid toggled every other cycle, with fetch = 1, pc = 3 held throughout the load -> ins_valid stays 0 and ins unchanged; all 16 words correct afterwards.
4. Restart mid-load: after 6 beats, pulse load_start together with load_valid (data 0x1FF) -> 0x1FF is not written; the next beat lands at address 0; load_done set only after 16 further beats.
5. Reset mid-load: assert rst after 9 beats -> busy = 0, load_done = 0, all entries read 0x000.
6. Simultaneous fetch and load_start in IDLE with mem[2] = 0x0A4 and pc = 2 -> next cycle ins = 0x0A4, ins_valid = 1, busy = 1.
